// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer.
//   seq_state_e : sequencer states (PLL_RESET=0 .. RUN=4)
//   Def*        : default parameter values
//   cnt_width() : register width needed to hold the values 0..n_values-1
package pll_reset_sequencer_pkg;

  typedef enum logic [2:0] {
    StPllReset = 3'd0,
    StWaitLock = 3'd1,
    StFilter   = 3'd2,
    StRelease  = 3'd3,
    StRun      = 3'd4
  } seq_state_e;

  localparam int unsigned DefNumDomains   = 4;
  localparam int unsigned DefPllRstCycles = 4;
  localparam int unsigned DefLockFilter   = 16;
  localparam int unsigned DefStageGap     = 8;
  localparam int unsigned DefTimeout      = 65536;
  localparam int unsigned RetryW          = 4;

  function automatic int unsigned cnt_width(input int unsigned n_values);
    return (n_values <= 2) ? 1 : $clog2(n_values);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Signals between the reset sequencer and the PLL / downstream domains.
//   master : the sequencer (drives PLL reset, domain resets, status)
//   slave  : the environment (drives pll_locked and soft_reset_req)
interface pll_reset_sequencer_if #(
  parameter int unsigned NUM_DOMAINS = pll_reset_sequencer_pkg::DefNumDomains
);
  logic                   pll_locked;
  logic                   soft_reset_req;
  logic                   pll_rst;
  logic [NUM_DOMAINS-1:0] domain_rst_n;
  logic                   ready;
  logic                   lock_lost;
  logic [3:0]             retry_count;

  modport master (
    input  pll_locked, soft_reset_req,
    output pll_rst, domain_rst_n, ready, lock_lost, retry_count
  );

  modport slave (
    output pll_locked, soft_reset_req,
    input  pll_rst, domain_rst_n, ready, lock_lost, retry_count
  );
endinterface

// File: rtl/pll_reset_sequencer_sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, output resets to 0
//   d_i    : asynchronous input
//   q_o    : synchronized output, two cycles of latency
module pll_reset_sequencer_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a filtered lock, then
// releases downstream domain resets one at a time, STAGE_GAP cycles apart.
// Retries the PLL on lock timeout; re-sequences on lock loss or soft request.
//   clk    : free-running reference clock
//   rst_n  : asynchronous active-low reset
//   seq_io : master side of pll_reset_sequencer_if (pll_locked, soft_reset_req
//            in; pll_rst, domain_rst_n, ready, lock_lost, retry_count out)
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS    = DefNumDomains,
  parameter int unsigned PLL_RST_CYCLES = DefPllRstCycles,
  parameter int unsigned LOCK_FILTER    = DefLockFilter,
  parameter int unsigned STAGE_GAP      = DefStageGap,
  parameter int unsigned TIMEOUT        = DefTimeout
) (
  input logic                   clk,
  input logic                   rst_n,
  pll_reset_sequencer_if.master seq_io
);

  localparam int unsigned PllCntW = cnt_width(PLL_RST_CYCLES);
  localparam int unsigned TmoCntW = cnt_width(TIMEOUT);
  localparam int unsigned FltCntW = cnt_width(LOCK_FILTER);
  localparam int unsigned GapCntW = cnt_width(STAGE_GAP);

  localparam logic [PllCntW-1:0]     PllCntLast = PllCntW'(PLL_RST_CYCLES - 1);
  localparam logic [TmoCntW-1:0]     TmoCntLast = TmoCntW'(TIMEOUT - 1);
  localparam logic [FltCntW-1:0]     FltCntLast = FltCntW'(LOCK_FILTER - 1);
  localparam logic [GapCntW-1:0]     GapCntLast = GapCntW'(STAGE_GAP - 1);
  localparam logic [NUM_DOMAINS-1:0] DomFirst   = NUM_DOMAINS'(1);

  seq_state_e             state_q, state_d;
  logic [PllCntW-1:0]     pll_cnt_q, pll_cnt_d;
  logic [TmoCntW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [FltCntW-1:0]     flt_cnt_q, flt_cnt_d;
  logic [GapCntW-1:0]     gap_cnt_q, gap_cnt_d;
  logic                   pll_rst_q, pll_rst_d;
  logic [NUM_DOMAINS-1:0] domain_q, domain_d;
  logic                   ready_q, ready_d;
  logic                   lock_lost_q, lock_lost_d;
  logic [RetryW-1:0]      retry_q, retry_d;
  logic                   locked_s;
  logic                   restart;

  pll_reset_sequencer_sync2 u_lock_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (seq_io.pll_locked),
    .q_o    (locked_s)
  );

  always_comb begin
    state_d     = state_q;
    pll_cnt_d   = pll_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    flt_cnt_d   = flt_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    pll_rst_d   = pll_rst_q;
    domain_d    = domain_q;
    ready_d     = ready_q;
    lock_lost_d = 1'b0;
    retry_d     = retry_q;
    restart     = 1'b0;

    unique case (state_q)
      StPllReset: begin
        if (seq_io.soft_reset_req) begin
          pll_cnt_d = '0;
        end else if (pll_cnt_q == PllCntLast) begin
          state_d   = StWaitLock;
          pll_rst_d = 1'b0;
          tmo_cnt_d = '0;
        end else begin
          pll_cnt_d = pll_cnt_q + 1'b1;
        end
      end

      StWaitLock: begin
        if (seq_io.soft_reset_req) begin
          restart = 1'b1;
        end else if (locked_s) begin
          state_d   = StFilter;
          flt_cnt_d = '0;
        end else if (tmo_cnt_q == TmoCntLast) begin
          restart = 1'b1;
          if (retry_q != '1) retry_d = retry_q + 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      StFilter: begin
        if (seq_io.soft_reset_req) begin
          restart = 1'b1;
        end else if (!locked_s) begin
          state_d   = StWaitLock;
          tmo_cnt_d = '0;
        end else if (flt_cnt_q == FltCntLast) begin
          state_d   = StRelease;
          domain_d  = DomFirst;
          gap_cnt_d = '0;
        end else begin
          flt_cnt_d = flt_cnt_q + 1'b1;
        end
      end

      StRelease, StRun: begin
        // Lock loss wins over a simultaneous soft request so lock_lost pulses.
        if (!locked_s) begin
          restart     = 1'b1;
          lock_lost_d = 1'b1;
        end else if (seq_io.soft_reset_req) begin
          restart = 1'b1;
        end else if (state_q == StRelease) begin
          if (domain_q[NUM_DOMAINS-1]) begin
            state_d = StRun;
            ready_d = 1'b1;
          end else if (gap_cnt_q == GapCntLast) begin
            // Domains are released as a thermometer code, so order is implicit.
            domain_d  = (domain_q << 1) | DomFirst;
            gap_cnt_d = '0;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
      end

      default: restart = 1'b1;
    endcase

    if (restart) begin
      state_d   = StPllReset;
      pll_rst_d = 1'b1;
      pll_cnt_d = '0;
      tmo_cnt_d = '0;
      flt_cnt_d = '0;
      gap_cnt_d = '0;
      domain_d  = '0;
      ready_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StPllReset;
      pll_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      flt_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      pll_rst_q   <= 1'b1;
      domain_q    <= '0;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      retry_q     <= '0;
    end else begin
      state_q     <= state_d;
      pll_cnt_q   <= pll_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      flt_cnt_q   <= flt_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      pll_rst_q   <= pll_rst_d;
      domain_q    <= domain_d;
      ready_q     <= ready_d;
      lock_lost_q <= lock_lost_d;
      retry_q     <= retry_d;
    end
  end

  assign seq_io.pll_rst      = pll_rst_q;
  assign seq_io.domain_rst_n = domain_q;
  assign seq_io.ready        = ready_q;
  assign seq_io.lock_lost    = lock_lost_q;
  assign seq_io.retry_count  = retry_q;

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Controls the board PLL and sequences resets for the logic clocked by the PLL output. It holds the PLL in reset, waits for a filtered lock, then releases downstream domain resets one at a time. It retries the PLL on lock timeout and re-sequences on lock loss or a software request. It sits between the PLL instance and every peripheral and core reset input.

Parameters:
NUM_DOMAINS, 4, number of staged downstream reset outputs (1..16)
PLL_RST_CYCLES, 4, cycles pll_rst is held high per PLL reset pulse (>=1)
LOCK_FILTER, 16, consecutive synchronized-locked cycles required before release (>=1)
STAGE_GAP, 8, cycles between successive domain releases (>=1)
TIMEOUT, 65536, cycles allowed in WAIT_LOCK before the PLL is re-pulsed (>=2)

Ports:
clk  in  1  free-running reference clock (CLOCK_50 domain)
rst_n  in  1  reset; asynchronous and active-low
pll_locked  in  1  PLL lock flag, asynchronous to clk
soft_reset_req  in  1  single-cycle request to re-sequence the PLL and all domains
pll_rst  out  1  PLL reset, active-high
domain_rst_n  out  NUM_DOMAINS  per-domain reset, active-low, released in index order
ready  out  1  high when all domains are released and lock is stable
lock_lost  out  1  one-cycle pulse on loss of lock after filtering completed
retry_count  out  4  count of lock timeouts, saturates at 15

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0: state=PLL_RESET, pll_rst=1, domain_rst_n=all 0, ready=0, lock_lost=0, retry_count=0, all counters 0.
- All outputs are registered. pll_locked passes through a 2-flop synchronizer; the result is locked_s, with 2 cycles of latency.
- PLL_RESET:
  - pll_rst=1 for exactly PLL_RST_CYCLES cycles, then go to WAIT_LOCK.
  - pll_rst falls on the same edge as the state change.
- WAIT_LOCK:
  - Timeout counter increments each cycle.
  - locked_s=1: go to FILTER and clear the filter counter.
  - Counter reaches TIMEOUT-1 with locked_s=0: go to PLL_RESET, pll_rst=1, retry_count+1 (saturating at 15).
- FILTER:
  - Filter counter increments while locked_s=1.
  - locked_s=0: go to WAIT_LOCK and clear the timeout counter.
  - LOCK_FILTER consecutive cycles of locked_s=1: go to RELEASE, domain_rst_n[0]=1 on that edge.
- RELEASE:
  - domain_rst_n[k] rises exactly STAGE_GAP*k cycles after domain_rst_n[0].
  - One cycle after the last domain rises, ready=1 and the state goes to RUN.
  - With NUM_DOMAINS=1, ready rises one cycle after domain_rst_n[0].
- RUN: holds until lock loss or a soft request.
- Lock loss in RELEASE or RUN (locked_s=0), on the next edge:
  - domain_rst_n=all 0, ready=0, lock_lost=1 for exactly one cycle.
  - state=PLL_RESET, pll_rst=1.
  - retry_count is unchanged.
- soft_reset_req in RELEASE or RUN: same as lock loss, but lock_lost stays 0.
- soft_reset_req in WAIT_LOCK or FILTER: go to PLL_RESET, pll_rst=1, counters cleared.
- soft_reset_req in PLL_RESET: restarts the PLL_RESET cycle count.
- Simultaneous lock loss and soft_reset_req: handled as lock loss, so lock_lost pulses.
- Invariants:
  - domain_rst_n bits are never released out of order.
  - No domain is released unless pll_rst=0.
  - ready=1 implies domain_rst_n is all 1s.
- rst_n asserted mid-sequence: every output returns to its reset value immediately, asynchronously.
- Counter widths: $clog2 of the largest count each counter reaches, with no wrap. The timeout counter is compared, never wraps.

Decomposition:
- Shared header pll_seq_defs.vh holds:
  - state encodings PLL_RESET=0, WAIT_LOCK=1, FILTER=2, RELEASE=3, RUN=4;
  - the default parameter constants.
- One sub-module, sync2: a 2-flop synchronizer with asynchronous active-low reset to 0. It is reused for other asynchronous inputs.

Test Plan:
Defaults except TIMEOUT=64; cycle 0 is the first clk edge after rst_n rises.
1. Power-up, pll_locked=1 constantly -> pll_rst high for cycles 0-3; domain_rst_n[0] rises 16 cycles after locked_s is first seen in FILTER; [1], [2], [3] follow at +8, +16, +24; ready rises at +25; lock_lost never pulses.
2. pll_locked held 0 -> pll_rst re-pulses for 4 cycles after every 64 WAIT_LOCK cycles; retry_count goes 1, 2, 3 … and holds at 15 after 15 timeouts; domain_rst_n stays 0.
3. Glitchy lock, locked high 10 cycles, low 1, then high → FILTER falls back to WAIT_LOCK; release occurs only after 16 uninterrupted high cycles.
4. In RUN, drop pll_locked → 3 cycles later (2 sync cycles + 1 registered): domain_rst_n=0000, ready=0, a 1-cycle lock_lost pulse, pll_rst=1 for 4 cycles, then a full re-sequence.
5. soft_reset_req during RELEASE after domain 1 is released → all domains reset next cycle; lock_lost=0; retry_count unchanged; in-order re-release follows.
6. Assert rst_n low asynchronously mid-RELEASE (between edges) → all outputs take their reset values before the next edge; a clean restart follows.
